lsu_split_ctrl: RTL
===================

Name: lsu_split_ctrl

Overview:
- Sequential load/store unit for the 3-stage core. Sits between the DE stage and the data-memory bus.
- Accepts one load/store per handshake, generates byte-lane masks, and drives a request/grant/response memory bus with variable latency.
- Splits accesses that cross a bus word into two beats and reassembles them, or flags them as misaligned.
- Returns sign/zero-extended load data with an error flag.

Parameters:
- DATA_W, 32, bus/register width; legal values 32 or 64. NB = DATA_W/8.
- ADDR_W, 32, byte address width.
- SPLIT_EN, 1, 1 = split word-crossing accesses into two beats; 0 = report them as errors with no bus access.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  core request valid
- req_ready  out  1  unit idle, can accept a request
- req_store  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V funct3 (size and sign)
- req_addr  in  ADDR_W  byte address (ALU result)
- req_wdata  in  DATA_W  store data, right-aligned (rs2)
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  DATA_W  extended load data; 0 for stores and on error
- rsp_err  out  1  misaligned (SPLIT_EN=0), illegal funct3, or bus error
- mem_req  out  1  bus request
- mem_gnt  in  1  bus accepted request this cycle
- mem_we  out  1  write enable
- mem_addr  out  ADDR_W  word-aligned address (low log2(NB) bits are 0)
- mem_wdata  out  DATA_W  lane-positioned store data
- mem_mask  out  NB  byte-lane enables
- mem_rvalid  in  1  read data or write acknowledge
- mem_rdata  in  DATA_W  read data
- mem_err  in  1  bus error, qualified by mem_rvalid

Behaviour:
- Reset: all outputs 0 except req_ready = 1. State = IDLE.
- Size from funct3[1:0]: 00 = 1 byte, 01 = 2, 10 = 4, 11 = 8.
  - funct3[2] = 1 means unsigned; loads only.
  - Legal set: LB, LH, LW, LBU, LHU, SB, SH, SW. With DATA_W=64, LD, LWU and SD are also legal.
  - All other codes are illegal: no bus access, rsp_err = 1.
- off = addr[log2(NB)-1:0]. An access crosses when off + size > NB.
- Handshake: accept when req_valid && req_ready. Request fields are registered on accept.
- req_ready = 1 only in IDLE.
- States:
  - IDLE: on accept, go to ERR if illegal, or if crossing with SPLIT_EN=0. Otherwise go to REQ with beat = 0.
  - REQ: mem_req = 1, fields held stable until mem_gnt. On mem_gnt go to WAIT.
  - WAIT: on mem_rvalid, capture lanes.
    - If mem_err, go to RESP with err = 1 (beat 1 is not issued).
    - Else if crossing and beat == 0, set beat = 1 and go to REQ.
    - Else go to RESP.
  - ERR: rsp_valid = 1, rsp_err = 1, rsp_rdata = 0, go to IDLE.
  - RESP: rsp_valid = 1 with registered rdata and err, go to IDLE.
- Beat 0:
  - mem_addr = addr with low bits cleared.
  - Mask = lanes off .. min(off+size, NB)-1.
  - wdata = req_wdata << (8*off).
- Beat 1 (crossing only):
  - mem_addr = beat-0 address + NB, wrapping modulo 2^ADDR_W.
  - Mask = lanes 0 .. off+size-NB-1.
  - Data = the upper bytes of req_wdata, starting at lane 0.
- Loads: bytes from both beats are concatenated (beat 0 is low), then sign- or zero-extended to DATA_W.
- Stores complete on the write acknowledge (mem_rvalid). rsp_rdata = 0 for stores.
- Latency with gnt in the REQ cycle and rvalid one cycle later: accept at T, rsp_valid at T+3 (aligned) or T+5 (split). Illegal or misaligned errors respond at T+1.
- mem_rvalid is ignored outside WAIT. mem_gnt is ignored outside REQ.
- The unit never has more than one outstanding beat.
- rst at any time returns to IDLE on the next edge and drops mem_req. A pending response is discarded, and late rvalids are ignored.

Decomposition:
- Shared package lsu_pkg:
  - funct3 constants (LB…SD).
  - State enum: IDLE, REQ, WAIT, RESP, ERR.
  - Function size_of(funct3).
  - Function is_legal(funct3, store, DATA_W).
- Sub-module lsu_lane_align (combinational, parametrised by DATA_W):
  - From off, size and beat it produces mask and shifted wdata.
  - Load-side: byte extraction and extension.
- The top level holds the FSM, request registers and load assembly register.

Test Plan:
- DATA_W=32: LW at 0x100, gnt immediate, rvalid with 0x8899AABB one cycle later → mem_addr 0x100, mask 1111, rsp_valid at T+3, rdata 0x8899AABB, err 0.
- LB and LBU at 0x103 with rdata 0x80xxxxxx → mask 1000; LB gives 0xFFFFFF80, LBU gives 0x00000080.
- SW of 0xDEADBEEF at 0x102, SPLIT_EN=1 → beat 0: addr 0x100, mask 1100, wdata 0xBEEF0000. Beat 1: addr 0x104, mask 0011, wdata 0x0000DEAD. rsp at T+5.
- Same access with SPLIT_EN=0 → no mem_req, rsp_err = 1 at T+1. funct3 = 011 at DATA_W=32 behaves the same way.
- LH at 0x103 with beat 0 returning mem_err → no beat 1, rsp_err = 1, rdata 0. A held-off gnt (5 cycles) keeps mem_addr and mem_mask stable.
- Assert rst while in WAIT → IDLE with req_ready = 1 next cycle. A subsequent stray mem_rvalid produces no rsp_valid.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states and
// the size/legality helpers used by the controller.
package lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_SD  = 3'b011;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    RESP,
    ERR
  } state_t;

  // Access size in bytes: 1, 2, 4 or 8.
  function automatic logic [3:0] size_of(input logic [2:0] funct3);
    return 4'd1 << funct3[1:0];
  endfunction

  // Doubleword and LWU only exist when the bus is 64 bits wide.
  function automatic logic is_legal(input logic [2:0] funct3, input logic store,
                                    input int data_w);
    logic ok;
    ok = 1'b0;
    if (store) begin
      case (funct3)
        F3_SB, F3_SH, F3_SW: ok = 1'b1;
        F3_SD:               ok = (data_w == 64);
        default:             ok = 1'b0;
      endcase
    end else begin
      case (funct3)
        F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: ok = 1'b1;
        F3_LD, F3_LWU:                       ok = (data_w == 64);
        default:                             ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering for one bus beat: store mask/data placement and
// load byte extraction with sign/zero extension.
module lsu_lane_align #(
  parameter int DATA_W = 32
) (
  input  logic [$clog2(DATA_W/8)-1:0] off,
  input  logic [3:0]                  size,
  input  logic                        beat,
  input  logic [DATA_W-1:0]           wdata,
  input  logic [2*DATA_W-1:0]         rbuf,
  input  logic                        is_unsigned,
  output logic [DATA_W/8-1:0]         mask,
  output logic [DATA_W-1:0]           lane_wdata,
  output logic [DATA_W-1:0]           ldata
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);

  logic [4:0]        end_lane;
  logic [4:0]        tail_lane;
  logic [OFF_W:0]    rem;
  logic [DATA_W-1:0] raw;
  logic              sign_bit;

  assign end_lane  = 5'(off) + 5'(size);
  assign tail_lane = end_lane - 5'(NB);
  assign rem       = (OFF_W + 1)'(NB) - {1'b0, off};

  // Beat 1 carries the bytes that did not fit in beat 0, starting at lane 0.
  assign lane_wdata = beat ? (wdata >> {rem, 3'b000}) : (wdata << {off, 3'b000});

  // rbuf holds beat 0 in the low word and beat 1 in the high word.
  assign raw = DATA_W'(rbuf >> {off, 3'b000});

  always_comb begin
    sign_bit = 1'b0;
    case (size)
      4'd1:    sign_bit = raw[7];
      4'd2:    sign_bit = raw[15];
      4'd4:    sign_bit = raw[31];
      default: sign_bit = raw[DATA_W-1];
    endcase
    if (is_unsigned) sign_bit = 1'b0;
  end

  for (genvar gi = 0; gi < NB; gi++) begin : g_lane
    assign mask[gi] = beat ? (5'(gi) < tail_lane)
                           : ((5'(gi) >= 5'(off)) && (5'(gi) < end_lane));
    assign ldata[8*gi +: 8] = (4'(gi) < size) ? raw[8*gi +: 8] : {8{sign_bit}};
  end

endmodule

// File: rtl/lsu_split_ctrl.sv
// Load/store unit: accepts one access at a time, drives the request/grant/
// response bus and splits word-crossing accesses into two beats.
module lsu_split_ctrl
  import lsu_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter bit SPLIT_EN = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_store,
  input  logic [2:0]          req_funct3,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                mem_req,
  input  logic                mem_gnt,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_mask,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_err
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);

  state_t              state_reg;
  logic                req_ready_reg;
  logic                rsp_valid_reg;
  logic                rsp_err_reg;
  logic [DATA_W-1:0]   rsp_rdata_reg;
  logic                mem_req_reg;
  logic                mem_we_reg;
  logic [ADDR_W-1:0]   mem_addr_reg;
  logic [DATA_W-1:0]   mem_wdata_reg;
  logic [NB-1:0]       mem_mask_reg;
  logic                store_reg;
  logic                beat_reg;
  logic                cross_reg;
  logic [2:0]          funct3_reg;
  logic [OFF_W-1:0]    off_reg;
  logic [DATA_W-1:0]   wdata_reg;
  logic [DATA_W-1:0]   rbuf_lo_reg;

  logic                accept;
  logic [OFF_W-1:0]    req_off;
  logic [3:0]          req_size;
  logic                req_cross;
  logic                req_legal;
  logic [ADDR_W-1:0]   req_word_addr;

  logic [OFF_W-1:0]    al_off;
  logic [3:0]          al_size;
  logic                al_beat;
  logic [DATA_W-1:0]   al_wdata;
  logic [2*DATA_W-1:0] al_rbuf;
  logic [NB-1:0]       al_mask;
  logic [DATA_W-1:0]   al_lane_wdata;
  logic [DATA_W-1:0]   al_ldata;

  assign accept        = req_valid && req_ready_reg;
  assign req_off       = req_addr[OFF_W-1:0];
  assign req_size      = size_of(req_funct3);
  assign req_cross     = (5'(req_off) + 5'(req_size)) > 5'(NB);
  assign req_legal     = is_legal(req_funct3, req_store, DATA_W);
  assign req_word_addr = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

  // In IDLE the aligner sees the incoming request (beat 0); afterwards it
  // sees the registered request, which is only needed to build beat 1.
  assign al_off   = (state_reg == IDLE) ? req_off   : off_reg;
  assign al_size  = (state_reg == IDLE) ? req_size  : size_of(funct3_reg);
  assign al_beat  = (state_reg != IDLE);
  assign al_wdata = (state_reg == IDLE) ? req_wdata : wdata_reg;
  assign al_rbuf  = beat_reg ? {mem_rdata, rbuf_lo_reg} : {{DATA_W{1'b0}}, mem_rdata};

  lsu_lane_align #(
    .DATA_W(DATA_W)
  ) u_align (
    .off         (al_off),
    .size        (al_size),
    .beat        (al_beat),
    .wdata       (al_wdata),
    .rbuf        (al_rbuf),
    .is_unsigned (funct3_reg[2]),
    .mask        (al_mask),
    .lane_wdata  (al_lane_wdata),
    .ldata       (al_ldata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      req_ready_reg <= 1'b1;
      rsp_valid_reg <= 1'b0;
      rsp_err_reg   <= 1'b0;
      rsp_rdata_reg <= '0;
      mem_req_reg   <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      mem_mask_reg  <= '0;
      store_reg     <= 1'b0;
      beat_reg      <= 1'b0;
      cross_reg     <= 1'b0;
      funct3_reg    <= '0;
      off_reg       <= '0;
      wdata_reg     <= '0;
      rbuf_lo_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            store_reg     <= req_store;
            funct3_reg    <= req_funct3;
            off_reg       <= req_off;
            wdata_reg     <= req_wdata;
            cross_reg     <= req_cross;
            beat_reg      <= 1'b0;
            req_ready_reg <= 1'b0;
            if (!req_legal || (req_cross && !SPLIT_EN)) begin
              state_reg     <= ERR;
              rsp_valid_reg <= 1'b1;
              rsp_err_reg   <= 1'b1;
              rsp_rdata_reg <= '0;
            end else begin
              state_reg     <= REQ;
              mem_req_reg   <= 1'b1;
              mem_we_reg    <= req_store;
              mem_addr_reg  <= req_word_addr;
              mem_mask_reg  <= al_mask;
              mem_wdata_reg <= al_lane_wdata;
            end
          end
        end
        REQ: begin
          if (mem_gnt) begin
            mem_req_reg <= 1'b0;
            state_reg   <= WAIT;
          end
        end
        WAIT: begin
          if (mem_rvalid) begin
            if (mem_err) begin
              state_reg     <= RESP;
              rsp_valid_reg <= 1'b1;
              rsp_err_reg   <= 1'b1;
              rsp_rdata_reg <= '0;
            end else if (cross_reg && !beat_reg) begin
              beat_reg      <= 1'b1;
              rbuf_lo_reg   <= mem_rdata;
              state_reg     <= REQ;
              mem_req_reg   <= 1'b1;
              mem_addr_reg  <= mem_addr_reg + ADDR_W'(NB);
              mem_mask_reg  <= al_mask;
              mem_wdata_reg <= al_lane_wdata;
            end else begin
              state_reg     <= RESP;
              rsp_valid_reg <= 1'b1;
              rsp_err_reg   <= 1'b0;
              rsp_rdata_reg <= store_reg ? '0 : al_ldata;
            end
          end
        end
        RESP, ERR: begin
          rsp_valid_reg <= 1'b0;
          rsp_err_reg   <= 1'b0;
          rsp_rdata_reg <= '0;
          req_ready_reg <= 1'b1;
          state_reg     <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign req_ready = req_ready_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_err   = rsp_err_reg;
  assign rsp_rdata = rsp_rdata_reg;
  assign mem_req   = mem_req_reg;
  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign mem_mask  = mem_mask_reg;

endmodule
